// File: rtl/mode_counter.sv
// -----------------------------------------------------------------------------
// mode_counter
//
// Programmable up/down counter with an enable prescaler and four counting
// modes:
//   00 wrap     : free-running modulo 2^WIDTH, limit ignored
//   01 modulo   : counts 0..limit and wraps at limit (either direction)
//   10 saturate : stops at limit (up) or 0 (down); can step back off the rail
//   11 one-shot : stops at limit (up) or 0 (down); stays there until
//                 clr/load/rst or a mode change
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active high
//   clr       in   synchronous clear (count, prescaler, tc, FSM)
//   load      in   synchronous parallel load of load_val
//   load_val  in   [WIDTH] value for load
//   en        in   count enable, advances the prescaler
//   dir       in   1 = up, 0 = down
//   mode      in   [2] counting mode (see above)
//   limit     in   [WIDTH] endpoint for modes 01/10/11
//   prescale  in   [PRE_W] tick every prescale+1 enabled cycles
//   count     out  [WIDTH] current count, registered
//   tc        out  terminal-count pulse, registered, one cycle wide
//   done      out  high while the FSM sits in DONE
//
// Priority at each edge: rst > clr > load > tick > hold.
// -----------------------------------------------------------------------------
module mode_counter #(
  parameter int WIDTH = 16,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_MOD  = 2'b01;
  localparam logic [1:0] MODE_SAT  = 2'b10;
  localparam logic [1:0] MODE_ONE  = 2'b11;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Prescaler: a tick fires on the enabled cycle where pre_cnt matches
  // prescale. en low freezes it; clr/load restart it so the first tick after
  // either arrives prescale+1 enabled cycles later.
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick = en && (pre_cnt == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               pre_cnt <= '0;
    else if (clr || load)  pre_cnt <= '0;
    else if (en)           pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Counter / FSM next-state
  // ---------------------------------------------------------------------------
  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  // Which rail the saturate/one-shot FSM stopped on (1 = limit, 0 = zero).
  // Saturate needs it in DONE to tell "away from endpoint" from "toward".
  logic             end_up, end_up_nxt;

  logic [WIDTH-1:0] cnt_inc, cnt_dec;
  logic             at_zero, at_max, ge_lim;

  assign cnt_inc = count + CNT_ONE;
  assign cnt_dec = count - CNT_ONE;
  assign at_zero = (count == '0);
  assign at_max  = (count == CNT_MAX);
  assign ge_lim  = (count >= limit);

  always_comb begin
    count_nxt  = count;
    state_nxt  = state;
    tc_nxt     = 1'b0;
    end_up_nxt = end_up;

    if (clr) begin
      count_nxt = '0;
      state_nxt = ST_RUN;
    end else if (load) begin
      count_nxt = load_val;
      state_nxt = ST_RUN;
    end else if (state == ST_DONE && !mode[1]) begin
      // Left saturate/one-shot while parked: release the FSM, count untouched.
      state_nxt = ST_RUN;
    end else if (tick) begin
      case (mode)
        MODE_WRAP: begin
          if (dir) begin
            count_nxt = cnt_inc;
            tc_nxt    = at_max;
          end else begin
            count_nxt = cnt_dec;
            tc_nxt    = at_zero;
          end
        end

        MODE_MOD: begin
          if (dir) begin
            if (ge_lim) begin
              count_nxt = '0;
              tc_nxt    = 1'b1;
            end else begin
              count_nxt = cnt_inc;
            end
          end else begin
            // count > limit covers a limit lowered below the current count.
            if (at_zero || (count > limit)) begin
              count_nxt = limit;
              tc_nxt    = 1'b1;
            end else begin
              count_nxt = cnt_dec;
            end
          end
        end

        MODE_SAT, MODE_ONE: begin
          if (state == ST_RUN) begin
            if (dir) begin
              if (ge_lim) begin
                // Already at/past the endpoint: park without a pulse.
                state_nxt  = ST_DONE;
                end_up_nxt = 1'b1;
              end else if (cnt_inc == limit) begin
                count_nxt  = limit;
                tc_nxt     = 1'b1;
                state_nxt  = ST_DONE;
                end_up_nxt = 1'b1;
              end else begin
                count_nxt = cnt_inc;
              end
            end else begin
              if (at_zero) begin
                state_nxt  = ST_DONE;
                end_up_nxt = 1'b0;
              end else if (count == CNT_ONE) begin
                count_nxt  = '0;
                tc_nxt     = 1'b1;
                state_nxt  = ST_DONE;
                end_up_nxt = 1'b0;
              end else begin
                count_nxt = cnt_dec;
              end
            end
          end else if (mode == MODE_SAT && dir != end_up) begin
            // Stepping off the rail. Never wrap: a zero-limit park at 0
            // cannot step further down, nor max further up.
            if (dir && !at_max) begin
              count_nxt = cnt_inc;
              state_nxt = ST_RUN;
            end else if (!dir && !at_zero) begin
              count_nxt = cnt_dec;
              state_nxt = ST_RUN;
            end
          end
          // One-shot in DONE ignores ticks entirely.
        end

        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      tc     <= 1'b0;
      state  <= ST_RUN;
      end_up <= 1'b0;
    end else begin
      count  <= count_nxt;
      tc     <= tc_nxt;
      state  <= state_nxt;
      end_up <= end_up_nxt;
    end
  end

  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mode_counter.sv
// -----------------------------------------------------------------------------
// tb_mode_counter
//
// Directed test of mode_counter (WIDTH=4, PRE_W=4): reset, wrap, modulo with
// prescaler and enable freeze, back-to-back tc, saturate, one-shot, mode
// change out of DONE, clr/load/tick priority and asynchronous reset.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_mode_counter;

  localparam int WIDTH = 4;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;

  int checks = 0;
  int errors = 0;

  mode_counter #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .limit    (limit),
    .prescale (prescale),
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int c, input int t, input int d);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".tc"},    int'(tc),    t);
    chk({tag, ".done"},  int'(done),  d);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0;
    dir = 1'b1; mode = 2'b00; limit = '0; prescale = '0;
    #3;
    chk_out("reset", 0, 0, 0);
    step(1);
    rst = 1'b0;

    // ---- wrap up / down, load coinciding with a tick ----
    mode = 2'b00; dir = 1'b1; prescale = 0; en = 1'b1;
    load = 1'b1; load_val = 4'd14;
    step(1); chk_out("wrap_load", 14, 0, 0);
    load = 1'b0;
    step(1); chk_out("wrap_15", 15, 0, 0);
    step(1); chk_out("wrap_0",   0, 1, 0);
    step(1); chk_out("wrap_1",   1, 0, 0);
    dir = 1'b0;
    step(1); chk_out("wrapdn_0",  0, 0, 0);
    step(1); chk_out("wrapdn_15", 15, 1, 0);

    // ---- modulo down with prescale=2 and enable freeze ----
    en = 1'b0; mode = 2'b01; limit = 4'd5; prescale = 4'd2; dir = 1'b0;
    clr = 1'b1;
    step(1); chk_out("mod_clr", 0, 0, 0);
    clr = 1'b0; en = 1'b1;
    step(2); chk_out("mod_wait", 0, 0, 0);
    step(1); chk_out("mod_5", 5, 1, 0);
    step(2); chk("mod_5_hold", int'(count), 5);
    step(1); chk_out("mod_4", 4, 0, 0);
    step(1);                       // pre_cnt 0 -> 1
    en = 1'b0;
    step(4); chk_out("mod_frozen", 4, 0, 0);
    en = 1'b1;
    step(1); chk("mod_resume_wait", int'(count), 4);
    step(1); chk_out("mod_3", 3, 0, 0);

    // ---- modulo up, limit=2, starting above limit ----
    prescale = 0; dir = 1'b1; limit = 4'd2;
    load = 1'b1; load_val = 4'd3;
    step(1); load = 1'b0;
    step(1); chk_out("modup_over", 0, 1, 0);
    step(1); chk_out("modup_1", 1, 0, 0);
    step(1); chk_out("modup_2", 2, 0, 0);
    step(1); chk_out("modup_wrap", 0, 1, 0);
    // limit=0: tc on every tick, back to back
    limit = 4'd0;
    step(1); chk_out("mod0_a", 0, 1, 0);
    step(1); chk_out("mod0_b", 0, 1, 0);

    // ---- saturate ----
    en = 1'b0; mode = 2'b10; limit = 4'd9; dir = 1'b1;
    load = 1'b1; load_val = 4'd7;
    step(1); chk_out("sat_load", 7, 0, 0);
    load = 1'b0; en = 1'b1;
    step(1); chk_out("sat_8", 8, 0, 0);
    step(1); chk_out("sat_9", 9, 1, 1);
    step(1); chk_out("sat_hold", 9, 0, 1);
    dir = 1'b0;
    step(1); chk_out("sat_away", 8, 0, 0);
    dir = 1'b1;
    step(1); chk_out("sat_again", 9, 1, 1);
    // leaving saturate while parked releases the FSM, count unchanged
    en = 1'b0; mode = 2'b00;
    step(1); chk_out("sat_modechg", 9, 0, 0);

    // ---- one-shot ----
    mode = 2'b11; limit = 4'd3; dir = 1'b1;
    clr = 1'b1;
    step(1); clr = 1'b0; en = 1'b1;
    step(1); chk_out("one_1", 1, 0, 0);
    step(1); chk_out("one_2", 2, 0, 0);
    step(1); chk_out("one_3", 3, 1, 1);
    dir = 1'b0;
    step(1); chk_out("one_ign_a", 3, 0, 1);
    step(1); chk_out("one_ign_b", 3, 0, 1);
    load = 1'b1; load_val = 4'd0;
    step(1); chk_out("one_load", 0, 0, 0);
    load = 1'b0; dir = 1'b1;
    step(1); chk_out("one_restart", 1, 0, 0);

    // ---- priority ----
    mode = 2'b00; dir = 1'b0; en = 1'b1;
    clr = 1'b1; load = 1'b1; load_val = 4'd7;
    step(1); chk_out("prio_clr", 0, 0, 0);
    clr = 1'b0; load = 1'b1; load_val = 4'd5;   // tick alone would give 15+tc
    step(1); chk_out("prio_load", 5, 0, 0);
    load = 1'b0;

    // ---- asynchronous reset mid-cycle ----
    en = 1'b0; mode = 2'b11; limit = 4'd6; dir = 1'b1;
    load = 1'b1; load_val = 4'd5;
    step(1); load = 1'b0; en = 1'b1;
    step(1); chk_out("pre_rst", 6, 1, 1);
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 0, 0, 0);
    #2 rst = 1'b0;
    mode = 2'b00; dir = 1'b1;
    step(1); chk_out("post_rst", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised, programmable up/down counter that replaces the fixed-width free-running counters in the design. It adds an enable prescaler and four counting modes (wrap, modulo, saturate, one-shot), with synchronous clear and parallel load. A registered terminal-count pulse and a done flag let timers, baud generators and event counters in the datapath use it directly.

## Interface
- WIDTH, 16: counter width in bits, ≥2.
- PRE_W, 8: prescaler width in bits, ≥1.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value loaded into count.
- en  in  1  count enable, feeds prescaler.
- dir  in  1  1 = up, 0 = down.
- mode  in  2  00 wrap, 01 modulo, 10 saturate, 11 one-shot.
- limit  in  WIDTH  endpoint for modes 01/10/11.
- prescale  in  PRE_W  tick every prescale+1 enabled cycles.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered.
- done  out  1  high while FSM is in DONE.

## Operation
- Priority at each edge: rst > clr > load > tick > hold.
- rst: count=0, pre_cnt=0, tc=0, state=RUN. done=0 asynchronously.
- clr: count=0, pre_cnt=0, tc=0, state=RUN.
- load: count=load_val, pre_cnt=0, tc=0, state=RUN. Load overrides a coincident tick.
- Prescaler: pre_cnt advances only when en=1. tick = en && (pre_cnt==prescale). On tick, pre_cnt→0, else pre_cnt+1. prescale=0 gives a tick on every enabled cycle. en=0 freezes pre_cnt.
- FSM has two states, RUN and DONE. Counting occurs only on tick.
- mode 00 wrap: modular 2^WIDTH arithmetic. tc on up 2^WIDTH−1→0 and on down 0→2^WIDTH−1. limit is ignored. State stays RUN.
- mode 01 modulo, up: if count≥limit then count→0 with tc, else count+1.
- mode 01 modulo, down: if count==0 or count>limit then count→limit with tc, else count−1.
- mode 01 modulo: limit=0 makes count stay at 0 with tc on every tick.
- mode 10 saturate, up: if count+1==limit, count→limit, tc, go to DONE. If count≥limit on tick, count holds and state→DONE with no tc.
- mode 10 saturate, down: same behaviour with endpoint 0.
- mode 10 saturate, in DONE: a tick whose dir moves away from the endpoint steps count by one and returns to RUN. Toward the endpoint, count holds.
- mode 11 one-shot: endpoint limit when up, 0 when down. Reaching the endpoint gives tc and DONE. In DONE, ticks are ignored regardless of dir. Exit only via clr, load, rst, or a mode change.
- mode change: takes effect on the next tick. Leaving modes 10/11 while in DONE forces RUN at the next edge with count unchanged.
- dir, limit and prescale are sampled every cycle. Changing them mid-count is legal and the rules above apply to the new values.

## Timing
- count, tc and done all update on the same edge. tc is high for exactly one cycle, the cycle in which count shows the endpoint or wrapped value.
- Latency: count changes on the edge that samples tick. First tick after load/clr arrives prescale+1 enabled cycles later.
- Back-to-back tc is legal (modulo with limit=0, prescale=0).
- rst mid-operation: outputs go to reset values immediately, with no clock required. Counting resumes on the first tick after rst deasserts.

## Test plan
- Wrap up: WIDTH=4, prescale=0, en=1, load 14 → count 15, 0, 1; tc high only in the cycle count=0.
- Modulo down with prescale: limit=5, prescale=2, count 0, dir=0 → count→5 with tc after 3 enabled cycles, then 4, 3 every 3 cycles. en low for 4 cycles freezes count and pre_cnt.
- Saturate: limit=9, load 7, up → 8, 9 (tc, done=1). Further ticks hold 9. dir=0 → 8, done=0.
- One-shot: limit=3, clr, up → 1, 2, 3 (tc, done). dir=0 ticks leave count at 3. load 0 → done=0, restart.
- Priority: clr, load and tick coincide → count=0. load and tick coincide → count=load_val, tc=0.
- Async reset: assert rst between edges at count=6 → count=0, tc=0, done=0 before the next edge.
